// File: rtl/cpu_defs.sv
// Shared encodings for the data-memory access stage: load/store selectors,
// the bus-sequencer state type and the default bus timeout.
package cpu_defs;

  localparam logic [2:0] LSEL_LW  = 3'b000;
  localparam logic [2:0] LSEL_LB  = 3'b001;
  localparam logic [2:0] LSEL_LH  = 3'b010;
  localparam logic [2:0] LSEL_LBU = 3'b101;
  localparam logic [2:0] LSEL_LHU = 3'b110;

  localparam logic [1:0] SSEL_SW  = 2'b00;
  localparam logic [1:0] SSEL_SB  = 2'b01;
  localparam logic [1:0] SSEL_SH  = 2'b10;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dm_state_t;

endpackage

// File: rtl/dm_be_gen.sv
// Byte-enable, store-lane and alignment decode for one data-memory access.
// Reserved selector codes fall back to full-word behaviour.
module dm_be_gen
  import cpu_defs::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  ssel,
  input  logic [2:0]  lsel,
  input  logic        is_store,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  // Decode enables, replicated write data and misalignment from the low address bits.
  always_comb begin
    be         = 4'b1111;
    wdata      = 32'h0;
    misaligned = 1'b0;
    if (is_store) begin
      case (ssel)
        SSEL_SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{wd[7:0]}};
        end
        SSEL_SH: begin
          be         = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata      = {2{wd[15:0]}};
          misaligned = addr_lo[0];
        end
        default: begin
          wdata      = wd;
          misaligned = |addr_lo;
        end
      endcase
    end else begin
      case (lsel)
        LSEL_LB, LSEL_LBU: misaligned = 1'b0;
        LSEL_LH, LSEL_LHU: misaligned = addr_lo[0];
        default:           misaligned = |addr_lo;
      endcase
    end
  end

endmodule

// File: rtl/dm_port.sv
// Data-memory access stage: issues word-aligned bus requests for M-stage
// loads/stores, stalls until ack or timeout, and registers results into W.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no bus traffic; aligned access in M launches a request
// WAIT    | request outstanding; ack completes, counter TC aborts
module dm_port
  import cpu_defs::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Valid_M,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  LSel_M,
  input  logic [1:0]  SSel_M,
  input  logic [31:0] A_M,
  input  logic [31:0] WD_M,
  output logic        Stall_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        Valid_W,
  output logic [31:0] DWRD_W,
  output logic [2:0]  LSel_W,
  output logic [31:0] A_W,
  output logic        AdEL_W,
  output logic        AdES_W,
  output logic        BusErr_W
);

  localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

  dm_state_t   state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        access, is_store, misaligned;
  logic        bus_start, bus_end;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        n_valid, n_adel, n_ades, n_buserr;
  logic [31:0] n_dwrd;

  assign access   = Valid_M & (MemRead_M | MemWrite_M);
  assign is_store = MemWrite_M;

  dm_be_gen u_be_gen (
    .addr_lo    (A_M[1:0]),
    .ssel       (SSel_M),
    .lsel       (LSel_M),
    .is_store   (is_store),
    .wd         (WD_M),
    .be         (be_c),
    .wdata      (wdata_c),
    .misaligned (misaligned)
  );

  // Next state, stall and the W-stage values; a stalled cycle leaves all W values at bubble defaults.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    Stall_M   = 1'b0;
    bus_start = 1'b0;
    bus_end   = 1'b0;
    n_valid   = 1'b0;
    n_dwrd    = 32'h0;
    n_adel    = 1'b0;
    n_ades    = 1'b0;
    n_buserr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access && !misaligned) begin
          Stall_M   = 1'b1;
          bus_start = 1'b1;
          cnt_nxt   = 8'h0;
          state_nxt = ST_WAIT;
        end else begin
          n_valid = Valid_M;
          n_adel  = access & misaligned & ~is_store;
          n_ades  = access & misaligned & is_store;
        end
      end
      ST_WAIT: begin
        if (bus_ack) begin
          n_valid   = Valid_M;
          n_dwrd    = bus_we ? 32'h0 : bus_rdata;
          bus_end   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_TC) begin
          n_valid   = Valid_M;
          n_buserr  = 1'b1;
          bus_end   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          Stall_M = 1'b1;
          cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, timeout counter, bus request registers and W-stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 8'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      Valid_W   <= 1'b0;
      DWRD_W    <= 32'h0;
      LSel_W    <= 3'b000;
      A_W       <= 32'h0;
      AdEL_W    <= 1'b0;
      AdES_W    <= 1'b0;
      BusErr_W  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (bus_start) begin
        bus_req   <= 1'b1;
        bus_we    <= is_store;
        bus_addr  <= {A_M[31:2], 2'b00};
        bus_be    <= be_c;
        bus_wdata <= wdata_c;
      end else if (bus_end) begin
        bus_req <= 1'b0;
      end
      Valid_W  <= n_valid;
      DWRD_W   <= n_dwrd;
      LSel_W   <= LSel_M;
      A_W      <= A_M;
      AdEL_W   <= n_adel;
      AdES_W   <= n_ades;
      BusErr_W <= n_buserr;
    end
  end

endmodule

// File: tb/tb_dm_port.sv
// Bench for dm_port: expected W-stage results are queued when an access is
// driven and popped when the access leaves M.
module tb_dm_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid_M, MemRead_M, MemWrite_M;
  logic [2:0]  LSel_M;
  logic [1:0]  SSel_M;
  logic [31:0] A_M, WD_M;
  logic        Stall_M, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        Valid_W, AdEL_W, AdES_W, BusErr_W;
  logic [31:0] DWRD_W, A_W;
  logic [2:0]  LSel_W;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [31:0] dwrd;
    logic [2:0]  lsel;
    logic [31:0] a;
    logic        adel;
    logic        ades;
    logic        buserr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  dm_port #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Valid_M(Valid_M), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
    .LSel_M(LSel_M), .SSel_M(SSel_M), .A_M(A_M), .WD_M(WD_M),
    .Stall_M(Stall_M), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .Valid_W(Valid_W), .DWRD_W(DWRD_W), .LSel_W(LSel_W), .A_W(A_W),
    .AdEL_W(AdEL_W), .AdES_W(AdES_W), .BusErr_W(BusErr_W)
  );

  // Observations from the most recent access.
  int          o_stalls, o_reqs;
  logic        o_first_req, o_we, o_bubble_bad, o_const_bad, o_timed_out, o_req_after;
  logic [3:0]  o_be;
  logic [31:0] o_wdata, o_addr;
  logic [72:0] w_got, w_exp;
  exp_t        e;

  // Holds one instruction in M until Stall_M drops, acking after ack_delay WAIT cycles (-1: never).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] lsel,
                            input logic [1:0] ssel, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata,
                            input int ack_delay);
    int   widx = 0;
    int   cyc = 0;
    logic done = 1'b0;
    o_stalls = 0; o_reqs = 0; o_first_req = 1'b0; o_we = 1'b0;
    o_be = 4'h0; o_wdata = 32'h0; o_addr = 32'h0;
    o_bubble_bad = 1'b0; o_const_bad = 1'b0; o_timed_out = 1'b0;
    Valid_M = 1'b1; MemRead_M = rd; MemWrite_M = wr;
    LSel_M = lsel; SSel_M = ssel; A_M = addr; WD_M = wd;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) o_first_req = bus_req;
      if (bus_req) begin
        if (o_reqs == 0) begin
          o_we = bus_we; o_be = bus_be; o_wdata = bus_wdata; o_addr = bus_addr;
        end else if (bus_we !== o_we || bus_be !== o_be || bus_wdata !== o_wdata
                     || bus_addr !== o_addr) begin
          o_const_bad = 1'b1;
        end
        if (Valid_W !== 1'b0) o_bubble_bad = 1'b1;
        o_reqs++;
        if (widx == ack_delay) begin
          bus_ack = 1'b1; bus_rdata = rdata;
        end
        widx++;
      end
      #1;
      if (Stall_M) o_stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = 32'h0;
      cyc++;
    end
    if (!done) o_timed_out = 1'b1;
    Valid_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
    o_req_after = bus_req;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Valid_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
    LSel_M = 3'b0; SSel_M = 2'b0; A_M = 32'h0; WD_M = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({Stall_M, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== 71'h0) begin
      failures++;
      $display("FAIL reset_bus: got %h expected 0",
               {Stall_M, bus_req, bus_we, bus_addr, bus_be, bus_wdata});
    end
    checks++;
    if ({Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W} !== 73'h0) begin
      failures++;
      $display("FAIL reset_w: got %h expected 0",
               {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sw();
    exp_q.push_back('{1'b1, 32'h0, 3'b000, 32'h100, 1'b0, 1'b0, 1'b0});
    run_access(1'b0, 1'b1, 3'b000, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    e = exp_q.pop_front();
    w_got = {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W};
    w_exp = {e.valid, e.dwrd, e.lsel, e.a, e.adel, e.ades, e.buserr};
    checks++;
    if (w_got !== w_exp) begin failures++; $display("FAIL sw_w: got %h expected %h", w_got, w_exp); end
    checks++;
    if (o_stalls !== 1) begin failures++; $display("FAIL sw_stalls: got %0d expected 1", o_stalls); end
    checks++;
    if ({o_we, o_be, o_addr, o_wdata} !== {1'b1, 4'b1111, 32'h100, 32'hDEADBEEF}) begin
      failures++; $display("FAIL sw_bus: got we=%b be=%b addr=%h wdata=%h expected we=1 be=1111 addr=00000100 wdata=deadbeef",
                           o_we, o_be, o_addr, o_wdata);
    end
    checks++;
    if (o_req_after !== 1'b0 || o_timed_out !== 1'b0) begin
      failures++; $display("FAIL sw_done: got req_after=%b timeout=%b expected 0 0", o_req_after, o_timed_out);
    end
  endtask

  task automatic test_sb();
    exp_q.push_back('{1'b1, 32'h0, 3'b000, 32'h103, 1'b0, 1'b0, 1'b0});
    run_access(1'b0, 1'b1, 3'b000, 2'b01, 32'h103, 32'h000000AB, 32'h0, 1);
    e = exp_q.pop_front();
    w_got = {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W};
    w_exp = {e.valid, e.dwrd, e.lsel, e.a, e.adel, e.ades, e.buserr};
    checks++;
    if (w_got !== w_exp) begin failures++; $display("FAIL sb_w: got %h expected %h", w_got, w_exp); end
    checks++;
    if ({o_be, o_addr, o_wdata} !== {4'b1000, 32'h100, 32'hABABABAB}) begin
      failures++; $display("FAIL sb_bus: got be=%b addr=%h wdata=%h expected be=1000 addr=00000100 wdata=abababab",
                           o_be, o_addr, o_wdata);
    end
    checks++;
    if (o_stalls !== 2 || o_const_bad !== 1'b0) begin
      failures++; $display("FAIL sb_timing: got stalls=%0d const_bad=%b expected 2 0", o_stalls, o_const_bad);
    end
  endtask

  task automatic test_sh_hi();
    exp_q.push_back('{1'b1, 32'h0, 3'b000, 32'h102, 1'b0, 1'b0, 1'b0});
    run_access(1'b0, 1'b1, 3'b000, 2'b10, 32'h102, 32'h55661234, 32'h0, 0);
    e = exp_q.pop_front();
    w_got = {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W};
    w_exp = {e.valid, e.dwrd, e.lsel, e.a, e.adel, e.ades, e.buserr};
    checks++;
    if (w_got !== w_exp) begin failures++; $display("FAIL sh_w: got %h expected %h", w_got, w_exp); end
    checks++;
    if ({o_be, o_wdata} !== {4'b1100, 32'h12341234}) begin
      failures++; $display("FAIL sh_bus: got be=%b wdata=%h expected be=1100 wdata=12341234", o_be, o_wdata);
    end
  endtask

  task automatic test_lh_delay();
    exp_q.push_back('{1'b1, 32'h80011234, 3'b010, 32'h102, 1'b0, 1'b0, 1'b0});
    run_access(1'b1, 1'b0, 3'b010, 2'b00, 32'h102, 32'h0, 32'h80011234, 3);
    e = exp_q.pop_front();
    w_got = {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W};
    w_exp = {e.valid, e.dwrd, e.lsel, e.a, e.adel, e.ades, e.buserr};
    checks++;
    if (w_got !== w_exp) begin failures++; $display("FAIL lh_w: got %h expected %h", w_got, w_exp); end
    checks++;
    if (o_stalls !== 4) begin failures++; $display("FAIL lh_stalls: got %0d expected 4", o_stalls); end
    checks++;
    if ({o_we, o_be, o_addr} !== {1'b0, 4'b1111, 32'h100}) begin
      failures++; $display("FAIL lh_bus: got we=%b be=%b addr=%h expected we=0 be=1111 addr=00000100", o_we, o_be, o_addr);
    end
    checks++;
    if (o_bubble_bad !== 1'b0 || o_const_bad !== 1'b0) begin
      failures++; $display("FAIL lh_stall_w: got bubble_bad=%b const_bad=%b expected 0 0", o_bubble_bad, o_const_bad);
    end
  endtask

  task automatic test_misaligned();
    exp_q.push_back('{1'b1, 32'h0, 3'b000, 32'h101, 1'b1, 1'b0, 1'b0});
    run_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h101, 32'h0, 32'h0, 0);
    e = exp_q.pop_front();
    w_got = {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W};
    w_exp = {e.valid, e.dwrd, e.lsel, e.a, e.adel, e.ades, e.buserr};
    checks++;
    if (w_got !== w_exp) begin failures++; $display("FAIL lw_mis_w: got %h expected %h", w_got, w_exp); end
    checks++;
    if (o_stalls !== 0 || o_reqs !== 0) begin
      failures++; $display("FAIL lw_mis_bus: got stalls=%0d reqs=%0d expected 0 0", o_stalls, o_reqs);
    end
    exp_q.push_back('{1'b1, 32'h0, 3'b000, 32'h003, 1'b0, 1'b1, 1'b0});
    run_access(1'b0, 1'b1, 3'b000, 2'b10, 32'h003, 32'h1234, 32'h0, 0);
    e = exp_q.pop_front();
    w_got = {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W};
    w_exp = {e.valid, e.dwrd, e.lsel, e.a, e.adel, e.ades, e.buserr};
    checks++;
    if (w_got !== w_exp) begin failures++; $display("FAIL sh_mis_w: got %h expected %h", w_got, w_exp); end
    checks++;
    if (o_stalls !== 0 || o_reqs !== 0) begin
      failures++; $display("FAIL sh_mis_bus: got stalls=%0d reqs=%0d expected 0 0", o_stalls, o_reqs);
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back('{1'b1, 32'h0, 3'b000, 32'h200, 1'b0, 1'b0, 1'b1});
    run_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h200, 32'h0, 32'h0, -1);
    e = exp_q.pop_front();
    w_got = {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W};
    w_exp = {e.valid, e.dwrd, e.lsel, e.a, e.adel, e.ades, e.buserr};
    checks++;
    if (w_got !== w_exp) begin failures++; $display("FAIL to_w: got %h expected %h", w_got, w_exp); end
    checks++;
    if (o_reqs !== 4 || o_stalls !== 4) begin
      failures++; $display("FAIL to_len: got reqs=%0d stalls=%0d expected 4 4", o_reqs, o_stalls);
    end
    checks++;
    if (o_req_after !== 1'b0 || o_timed_out !== 1'b0) begin
      failures++; $display("FAIL to_idle: got req_after=%b timeout=%b expected 0 0", o_req_after, o_timed_out);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{1'b1, 32'hCAFEF00D, 3'b000, 32'h400, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{1'b1, 32'h000000F1, 3'b101, 32'h405, 1'b0, 1'b0, 1'b0});
    run_access(1'b1, 1'b0, 3'b000, 2'b00, 32'h400, 32'h0, 32'hCAFEF00D, 0);
    e = exp_q.pop_front();
    w_got = {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W};
    w_exp = {e.valid, e.dwrd, e.lsel, e.a, e.adel, e.ades, e.buserr};
    checks++;
    if (w_got !== w_exp) begin failures++; $display("FAIL b2b_w0: got %h expected %h", w_got, w_exp); end
    // lbu with the store bit also set: store wins, so DWRD_W stays 0 and bus_we is 1.
    exp_q[0].dwrd = 32'h0;
    run_access(1'b1, 1'b1, 3'b101, 2'b01, 32'h405, 32'h77, 32'h000000F1, 0);
    e = exp_q.pop_front();
    w_got = {Valid_W, DWRD_W, LSel_W, A_W, AdEL_W, AdES_W, BusErr_W};
    w_exp = {e.valid, e.dwrd, e.lsel, e.a, e.adel, e.ades, e.buserr};
    checks++;
    if (w_got !== w_exp) begin failures++; $display("FAIL b2b_w1: got %h expected %h", w_got, w_exp); end
    checks++;
    if (o_first_req !== 1'b0 || o_stalls !== 1) begin
      failures++; $display("FAIL b2b_gap: got first_req=%b stalls=%0d expected 0 1", o_first_req, o_stalls);
    end
    checks++;
    if ({o_we, o_be, o_addr, o_wdata} !== {1'b1, 4'b0010, 32'h404, 32'h77777777}) begin
      failures++; $display("FAIL b2b_bus: got we=%b be=%b addr=%h wdata=%h expected we=1 be=0010 addr=00000404 wdata=77777777",
                           o_we, o_be, o_addr, o_wdata);
    end
  endtask

  task automatic test_reset_wait();
    int guard = 0;
    Valid_M = 1'b1; MemRead_M = 1'b1; MemWrite_M = 1'b0;
    LSel_M = 3'b000; SSel_M = 2'b00; A_M = 32'h300; WD_M = 32'h0;
    @(negedge clk);
    while (bus_req !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus_req !== 1'b1) begin failures++; $display("FAIL rw_start: got bus_req=%b expected 1", bus_req); end
    @(negedge clk);
    reset = 1'b1;
    Valid_M = 1'b0; MemRead_M = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({bus_req, Valid_W, Stall_M, BusErr_W} !== 4'b0000) begin
      failures++; $display("FAIL rw_abort: got req=%b valid_w=%b stall=%b buserr=%b expected 0 0 0 0",
                           bus_req, Valid_W, Stall_M, BusErr_W);
    end
    // Stray acks with no request pending must not produce a W result.
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    checks++;
    if ({bus_req, Valid_W, DWRD_W, BusErr_W} !== 35'h0) begin
      failures++; $display("FAIL ack_idle: got req=%b valid_w=%b dwrd=%h buserr=%b expected 0 0 0 0",
                           bus_req, Valid_W, DWRD_W, BusErr_W);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_sh_hi();
    test_lh_delay();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_port.md
# dm_port

Data-memory access stage of the MIPS pipeline, sitting between the M stage and the write-back load-extension logic. Turns M-stage load/store requests into word-aligned bus transactions with byte enables, stalls the pipeline until the bus acknowledges, and registers the raw read word, load selector and address into the W stage. Misaligned accesses and bus timeouts become W-stage exception flags instead of bus traffic.

## Interface
- TIMEOUT, 16: WAIT cycles without `bus_ack` before abort; legal range 2..255.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- Valid_M  in  1  M-stage instruction valid.
- MemRead_M  in  1  load.
- MemWrite_M  in  1  store.
- LSel_M  in  3  load type: 000 lw, 001 lb, 010 lh, 101 lbu, 110 lhu.
- SSel_M  in  2  store type: 00 sw, 01 sb, 10 sh, 11 reserved (treated as sw).
- A_M  in  32  effective byte address.
- WD_M  in  32  store data, right-justified.
- Stall_M  out  1  freeze M and earlier stages.
- bus_req  out  1  registered request, held until ack or abort.
- bus_we  out  1  write strobe.
- bus_addr  out  32  {A_M[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  completes the request in the same cycle.
- bus_rdata  in  32  valid when `bus_ack`.
- Valid_W, DWRD_W[31:0], LSel_W[2:0], A_W[31:0], AdEL_W, AdES_W, BusErr_W  out  W-stage registers.

## Operation
- Access = Valid_M & (MemRead_M | MemWrite_M). Both asserted: store wins.
- Alignment: lw/sw need A[1:0]=00; lh/lhu/sh need A[0]=0; bytes always aligned.
- Misaligned access: no bus request, no stall; W captures AdEL_W (load) or AdES_W (store), DWRD_W=0.
- Byte enables: sb 4'b0001<<A[1:0]; sh A[1]?1100:0011; sw 1111; loads 1111.
- Write data: sb {4{WD[7:0]}}, sh {2{WD[15:0]}}, sw WD.
- FSM states IDLE, WAIT.
  - IDLE, aligned access: Stall_M=1; at edge load bus_* registers, bus_req=1, clear counter, go WAIT.
  - IDLE otherwise: Stall_M=0; W registers capture pass-through.
  - WAIT, bus_ack=1: Stall_M=0; W captures DWRD_W=bus_rdata (0 for stores), bus_req=0, go IDLE.
  - WAIT, no ack, counter=TIMEOUT-1: Stall_M=0; bus_req=0; BusErr_W=1, DWRD_W=0; go IDLE.
  - WAIT, no ack otherwise: Stall_M=1, counter+1 (8-bit, saturating).
- W capture only when Stall_M=0; while stalled, W loads a bubble (Valid_W=0, flags 0) so no instruction writes back twice.
- LSel_W and A_W always copy LSel_M/A_M of the captured instruction; flags only on faulting instruction.
- bus_* outputs constant while bus_req=1.

## Timing
- Reset: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, counter 0, Valid_W 0, DWRD_W 0, LSel_W 000, A_W 0, all flags 0. Stall_M follows state (0 when M idle).
- Zero-wait memory: access spends 2 cycles in M (1 stall cycle); DWRD_W valid the cycle after ack.
- N-cycle ack delay: N+1 stall cycles.
- Back-to-back accesses: next request issues no earlier than the cycle after the previous ack (IDLE always intervenes).
- Reset mid-WAIT: bus_req dropped at the reset edge, transaction abandoned, no W update.
- bus_ack outside WAIT: ignored.

## Structure
- Package `cpu_defs`: LSel and SSel encodings, FSM state enum, TIMEOUT default.
- Sub-module `dm_be_gen` (combinational): A[1:0], SSel, LSel, read/write in → bus_be, bus_wdata, misaligned flag.

## Test plan
- sw A=0x100, WD=0xDEADBEEF, ack next cycle → bus_be=1111, bus_wdata=DEADBEEF, 1 stall cycle, Valid_W=1.
- sb A=0x103, WD=0x000000AB → bus_addr=0x100, bus_be=1000, bus_wdata=ABABABAB.
- lh A=0x102, ack after 3 cycles, rdata=0x8001_1234 → 4 stall cycles, DWRD_W=80011234, LSel_W=010, A_W=0x102.
- lw A=0x101 → no bus_req, Stall_M=0, AdEL_W=1, DWRD_W=0; sh A=0x003 → AdES_W=1.
- Load, no ack, TIMEOUT=4 → bus_req high 4 cycles, then BusErr_W=1, back to IDLE.
- reset asserted during WAIT → next cycle bus_req=0, Valid_W=0, state IDLE.
